// File: rtl/bcd_seq_ctrl.sv
// rtl/bcd_seq_ctrl.sv - iterative double-dabble binary-to-BCD converter with saturation
module bcd_seq_ctrl #(
    parameter int BIN_W   = 32,
    parameter int DIGITS  = 8,
    parameter int MAX_VAL = 99999999
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [BIN_W-1:0]   r_bin_shift;
    logic [BCD_W-1:0]   r_bcd_work;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_pending;
    logic               r_busy;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_overflow;

    logic [BCD_W-1:0]   w_bcd_adj;
    logic [BCD_W-1:0]   w_bcd_next;
    logic [BIN_W-1:0]   w_bin_next;

    // Add-3 correction on every digit, then one left shift of {bcd, bin}.
    always_comb begin
        w_bcd_adj = r_bcd_work;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd_work[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd_work[4*d +: 4] + 4'd3;
            end
        end
        w_bcd_next = {w_bcd_adj[BCD_W-2:0], r_bin_shift[BIN_W-1]};
        w_bin_next = {r_bin_shift[BIN_W-2:0], 1'b0};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= ST_IDLE;
            r_bin_shift   <= '0;
            r_bcd_work    <= '0;
            r_cnt         <= '0;
            r_ovf_pending <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_bcd         <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state       <= ST_SHIFT;
                        r_bin_shift   <= bin;
                        r_bcd_work    <= '0;
                        r_cnt         <= '0;
                        r_ovf_pending <= (bin > MAX_BIN);
                        r_busy        <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_bcd_work  <= w_bcd_next;
                    r_bin_shift <= w_bin_next;
                    r_cnt       <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_bcd      <= r_ovf_pending ? {DIGITS{4'h9}} : w_bcd_next;
                        r_overflow <= r_ovf_pending;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_overflow;

endmodule
